// File: rtl/uncached_tilelink_client_arbiter_pkg.sv
// Shared widths and encodings for the two-client uncached TileLink arbiter.
package uncached_tilelink_client_arbiter_pkg;

    localparam int ADDR_BLOCK_W    = 26;
    localparam int ADDR_BEAT_W     = 3;
    localparam int DATA_W          = 64;
    localparam int G_TYPE_W        = 4;
    localparam int A_TYPE_W        = 3;
    localparam int UNION_W         = 12;
    localparam int BEATS_PER_BLOCK = 8;
    localparam int BEAT_CNT_W      = 3;

    typedef enum logic [A_TYPE_W-1:0] {
        A_GET        = 3'h0,
        A_GET_BLOCK  = 3'h1,
        A_PUT        = 3'h2,
        A_PUT_BLOCK  = 3'h3,
        A_PUT_ATOMIC = 3'h4
    } a_type_e;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    function automatic logic is_put_block(input logic is_builtin, input logic [A_TYPE_W-1:0] a_type);
        return is_builtin && (a_type == A_PUT_BLOCK);
    endfunction

endpackage

// File: rtl/uncached_tilelink_client_arbiter_if.sv
// Bundle of both client ports and the merged router port; slave is the arbiter side.
interface uncached_tilelink_client_arbiter_if;
    import uncached_tilelink_client_arbiter_pkg::*;

    logic                    io_in_0_acquire_ready;
    logic                    io_in_0_acquire_valid;
    logic [ADDR_BLOCK_W-1:0] io_in_0_acquire_bits_addr_block;
    logic                    io_in_0_acquire_bits_client_xact_id;
    logic [ADDR_BEAT_W-1:0]  io_in_0_acquire_bits_addr_beat;
    logic                    io_in_0_acquire_bits_is_builtin_type;
    logic [A_TYPE_W-1:0]     io_in_0_acquire_bits_a_type;
    logic [UNION_W-1:0]      io_in_0_acquire_bits_union;
    logic [DATA_W-1:0]       io_in_0_acquire_bits_data;
    logic                    io_in_0_grant_ready;
    logic                    io_in_0_grant_valid;
    logic [ADDR_BEAT_W-1:0]  io_in_0_grant_bits_addr_beat;
    logic                    io_in_0_grant_bits_client_xact_id;
    logic                    io_in_0_grant_bits_manager_xact_id;
    logic                    io_in_0_grant_bits_is_builtin_type;
    logic [G_TYPE_W-1:0]     io_in_0_grant_bits_g_type;
    logic [DATA_W-1:0]       io_in_0_grant_bits_data;

    logic                    io_in_1_acquire_ready;
    logic                    io_in_1_acquire_valid;
    logic [ADDR_BLOCK_W-1:0] io_in_1_acquire_bits_addr_block;
    logic                    io_in_1_acquire_bits_client_xact_id;
    logic [ADDR_BEAT_W-1:0]  io_in_1_acquire_bits_addr_beat;
    logic                    io_in_1_acquire_bits_is_builtin_type;
    logic [A_TYPE_W-1:0]     io_in_1_acquire_bits_a_type;
    logic [UNION_W-1:0]      io_in_1_acquire_bits_union;
    logic [DATA_W-1:0]       io_in_1_acquire_bits_data;
    logic                    io_in_1_grant_ready;
    logic                    io_in_1_grant_valid;
    logic [ADDR_BEAT_W-1:0]  io_in_1_grant_bits_addr_beat;
    logic                    io_in_1_grant_bits_client_xact_id;
    logic                    io_in_1_grant_bits_manager_xact_id;
    logic                    io_in_1_grant_bits_is_builtin_type;
    logic [G_TYPE_W-1:0]     io_in_1_grant_bits_g_type;
    logic [DATA_W-1:0]       io_in_1_grant_bits_data;

    // Router side carries the owner index in client_xact_id[1].
    logic                    io_out_acquire_ready;
    logic                    io_out_acquire_valid;
    logic [ADDR_BLOCK_W-1:0] io_out_acquire_bits_addr_block;
    logic [1:0]              io_out_acquire_bits_client_xact_id;
    logic [ADDR_BEAT_W-1:0]  io_out_acquire_bits_addr_beat;
    logic                    io_out_acquire_bits_is_builtin_type;
    logic [A_TYPE_W-1:0]     io_out_acquire_bits_a_type;
    logic [UNION_W-1:0]      io_out_acquire_bits_union;
    logic [DATA_W-1:0]       io_out_acquire_bits_data;
    logic                    io_out_grant_ready;
    logic                    io_out_grant_valid;
    logic [ADDR_BEAT_W-1:0]  io_out_grant_bits_addr_beat;
    logic [1:0]              io_out_grant_bits_client_xact_id;
    logic                    io_out_grant_bits_manager_xact_id;
    logic                    io_out_grant_bits_is_builtin_type;
    logic [G_TYPE_W-1:0]     io_out_grant_bits_g_type;
    logic [DATA_W-1:0]       io_out_grant_bits_data;

    modport slave (
        input  io_in_0_acquire_valid, io_in_0_acquire_bits_addr_block,
               io_in_0_acquire_bits_client_xact_id, io_in_0_acquire_bits_addr_beat,
               io_in_0_acquire_bits_is_builtin_type, io_in_0_acquire_bits_a_type,
               io_in_0_acquire_bits_union, io_in_0_acquire_bits_data, io_in_0_grant_ready,
        input  io_in_1_acquire_valid, io_in_1_acquire_bits_addr_block,
               io_in_1_acquire_bits_client_xact_id, io_in_1_acquire_bits_addr_beat,
               io_in_1_acquire_bits_is_builtin_type, io_in_1_acquire_bits_a_type,
               io_in_1_acquire_bits_union, io_in_1_acquire_bits_data, io_in_1_grant_ready,
        input  io_out_acquire_ready, io_out_grant_valid, io_out_grant_bits_addr_beat,
               io_out_grant_bits_client_xact_id, io_out_grant_bits_manager_xact_id,
               io_out_grant_bits_is_builtin_type, io_out_grant_bits_g_type,
               io_out_grant_bits_data,
        output io_in_0_acquire_ready, io_in_0_grant_valid, io_in_0_grant_bits_addr_beat,
               io_in_0_grant_bits_client_xact_id, io_in_0_grant_bits_manager_xact_id,
               io_in_0_grant_bits_is_builtin_type, io_in_0_grant_bits_g_type,
               io_in_0_grant_bits_data,
        output io_in_1_acquire_ready, io_in_1_grant_valid, io_in_1_grant_bits_addr_beat,
               io_in_1_grant_bits_client_xact_id, io_in_1_grant_bits_manager_xact_id,
               io_in_1_grant_bits_is_builtin_type, io_in_1_grant_bits_g_type,
               io_in_1_grant_bits_data,
        output io_out_acquire_valid, io_out_acquire_bits_addr_block,
               io_out_acquire_bits_client_xact_id, io_out_acquire_bits_addr_beat,
               io_out_acquire_bits_is_builtin_type, io_out_acquire_bits_a_type,
               io_out_acquire_bits_union, io_out_acquire_bits_data, io_out_grant_ready
    );

    modport master (
        output io_in_0_acquire_valid, io_in_0_acquire_bits_addr_block,
               io_in_0_acquire_bits_client_xact_id, io_in_0_acquire_bits_addr_beat,
               io_in_0_acquire_bits_is_builtin_type, io_in_0_acquire_bits_a_type,
               io_in_0_acquire_bits_union, io_in_0_acquire_bits_data, io_in_0_grant_ready,
        output io_in_1_acquire_valid, io_in_1_acquire_bits_addr_block,
               io_in_1_acquire_bits_client_xact_id, io_in_1_acquire_bits_addr_beat,
               io_in_1_acquire_bits_is_builtin_type, io_in_1_acquire_bits_a_type,
               io_in_1_acquire_bits_union, io_in_1_acquire_bits_data, io_in_1_grant_ready,
        output io_out_acquire_ready, io_out_grant_valid, io_out_grant_bits_addr_beat,
               io_out_grant_bits_client_xact_id, io_out_grant_bits_manager_xact_id,
               io_out_grant_bits_is_builtin_type, io_out_grant_bits_g_type,
               io_out_grant_bits_data,
        input  io_in_0_acquire_ready, io_in_0_grant_valid, io_in_0_grant_bits_addr_beat,
               io_in_0_grant_bits_client_xact_id, io_in_0_grant_bits_manager_xact_id,
               io_in_0_grant_bits_is_builtin_type, io_in_0_grant_bits_g_type,
               io_in_0_grant_bits_data,
        input  io_in_1_acquire_ready, io_in_1_grant_valid, io_in_1_grant_bits_addr_beat,
               io_in_1_grant_bits_client_xact_id, io_in_1_grant_bits_manager_xact_id,
               io_in_1_grant_bits_is_builtin_type, io_in_1_grant_bits_g_type,
               io_in_1_grant_bits_data,
        input  io_out_acquire_valid, io_out_acquire_bits_addr_block,
               io_out_acquire_bits_client_xact_id, io_out_acquire_bits_addr_beat,
               io_out_acquire_bits_is_builtin_type, io_out_acquire_bits_a_type,
               io_out_acquire_bits_union, io_out_acquire_bits_data, io_out_grant_ready
    );

endinterface

// File: rtl/uncached_tilelink_client_arbiter_tl_locking_rr_select.sv
// Two-way round-robin owner select with a burst lock that pins the owner
// for all beats of a PutBlock.
module tl_locking_rr_select
    import uncached_tilelink_client_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_valid,
    input  logic       i_fire,
    input  logic       i_put_block,
    output logic       o_owner
);

    // state     | meaning
    // ST_OPEN   | no burst in flight; owner chosen round-robin after r_last
    // ST_LOCKED | PutBlock in flight; owner pinned to r_lock_owner until last beat

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS_PER_BLOCK - 1);

    lock_state_e           r_state;
    lock_state_e           w_state_nxt;
    logic                  r_last;
    logic                  w_last_nxt;
    logic                  r_lock_owner;
    logic                  w_lock_owner_nxt;
    logic [BEAT_CNT_W-1:0] r_beat_cnt;
    logic [BEAT_CNT_W-1:0] w_beat_cnt_nxt;
    logic                  w_last_eff;
    logic                  w_locked_eff;
    logic                  w_next_rr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_OPEN;
            r_last       <= 1'b1;
            r_lock_owner <= 1'b0;
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last       <= w_last_nxt;
            r_lock_owner <= w_lock_owner_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_nxt       = r_last;
        w_lock_owner_nxt = r_lock_owner;
        w_beat_cnt_nxt   = r_beat_cnt;
        if (i_fire) begin
            w_last_nxt = o_owner;
            case (r_state)
                ST_OPEN: begin
                    if (i_put_block) begin
                        w_state_nxt      = ST_LOCKED;
                        w_lock_owner_nxt = o_owner;
                        w_beat_cnt_nxt   = BEAT_CNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    // Any fire from the lock owner counts as a beat, PutBlock or not.
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_state_nxt    = ST_OPEN;
                        w_beat_cnt_nxt = '0;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + BEAT_CNT_W'(1);
                    end
                end
                default: w_state_nxt = ST_OPEN;
            endcase
        end
    end

    // While reset is held the select behaves as if already at reset values.
    always_comb begin
        w_last_eff   = reset ? 1'b1 : r_last;
        w_locked_eff = !reset && (r_state == ST_LOCKED);
        w_next_rr    = ~w_last_eff;
        if (w_locked_eff) begin
            o_owner = r_lock_owner;
        end else if (i_valid[w_next_rr] || !i_valid[w_last_eff]) begin
            o_owner = w_next_rr;
        end else begin
            o_owner = w_last_eff;
        end
    end

endmodule

// File: rtl/uncached_tilelink_client_arbiter.sv
// Two-client uncached TileLink arbiter: round-robin acquire merge with PutBlock
// burst lock, owner index tagged into the id MSB, grants steered back by that bit.
module uncached_tilelink_client_arbiter
    import uncached_tilelink_client_arbiter_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset,
    uncached_tilelink_client_arbiter_if.slave tl,
    output logic                              io_chosen
);

    logic [1:0] w_valid;
    logic       w_owner;
    logic       w_fire;
    logic       w_put_block;
    logic       w_gnt_target;

    assign w_valid = {tl.io_in_1_acquire_valid, tl.io_in_0_acquire_valid};

    tl_locking_rr_select u_select (
        .clk         (clk),
        .reset       (reset),
        .i_valid     (w_valid),
        .i_fire      (w_fire),
        .i_put_block (w_put_block),
        .o_owner     (w_owner)
    );

    assign io_chosen = w_owner;

    assign tl.io_out_acquire_valid = w_owner ? tl.io_in_1_acquire_valid
                                             : tl.io_in_0_acquire_valid;
    assign tl.io_out_acquire_bits_addr_block = w_owner ? tl.io_in_1_acquire_bits_addr_block
                                                       : tl.io_in_0_acquire_bits_addr_block;
    assign tl.io_out_acquire_bits_client_xact_id = {w_owner,
        w_owner ? tl.io_in_1_acquire_bits_client_xact_id : tl.io_in_0_acquire_bits_client_xact_id};
    assign tl.io_out_acquire_bits_addr_beat = w_owner ? tl.io_in_1_acquire_bits_addr_beat
                                                      : tl.io_in_0_acquire_bits_addr_beat;
    assign tl.io_out_acquire_bits_is_builtin_type = w_owner ? tl.io_in_1_acquire_bits_is_builtin_type
                                                            : tl.io_in_0_acquire_bits_is_builtin_type;
    assign tl.io_out_acquire_bits_a_type = w_owner ? tl.io_in_1_acquire_bits_a_type
                                                   : tl.io_in_0_acquire_bits_a_type;
    assign tl.io_out_acquire_bits_union = w_owner ? tl.io_in_1_acquire_bits_union
                                                  : tl.io_in_0_acquire_bits_union;
    assign tl.io_out_acquire_bits_data = w_owner ? tl.io_in_1_acquire_bits_data
                                                 : tl.io_in_0_acquire_bits_data;

    assign tl.io_in_0_acquire_ready = ~w_owner & tl.io_out_acquire_ready;
    assign tl.io_in_1_acquire_ready =  w_owner & tl.io_out_acquire_ready;

    assign w_fire      = tl.io_out_acquire_valid & tl.io_out_acquire_ready;
    assign w_put_block = is_put_block(tl.io_out_acquire_bits_is_builtin_type,
                                      tl.io_out_acquire_bits_a_type);

    // Grants carry no state: each beat is steered by its own id MSB.
    assign w_gnt_target = tl.io_out_grant_bits_client_xact_id[1];

    assign tl.io_in_0_grant_valid = tl.io_out_grant_valid & ~w_gnt_target;
    assign tl.io_in_1_grant_valid = tl.io_out_grant_valid &  w_gnt_target;
    assign tl.io_out_grant_ready  = w_gnt_target ? tl.io_in_1_grant_ready : tl.io_in_0_grant_ready;

    assign tl.io_in_0_grant_bits_addr_beat       = tl.io_out_grant_bits_addr_beat;
    assign tl.io_in_0_grant_bits_client_xact_id  = tl.io_out_grant_bits_client_xact_id[0];
    assign tl.io_in_0_grant_bits_manager_xact_id = tl.io_out_grant_bits_manager_xact_id;
    assign tl.io_in_0_grant_bits_is_builtin_type = tl.io_out_grant_bits_is_builtin_type;
    assign tl.io_in_0_grant_bits_g_type          = tl.io_out_grant_bits_g_type;
    assign tl.io_in_0_grant_bits_data            = tl.io_out_grant_bits_data;

    assign tl.io_in_1_grant_bits_addr_beat       = tl.io_out_grant_bits_addr_beat;
    assign tl.io_in_1_grant_bits_client_xact_id  = tl.io_out_grant_bits_client_xact_id[0];
    assign tl.io_in_1_grant_bits_manager_xact_id = tl.io_out_grant_bits_manager_xact_id;
    assign tl.io_in_1_grant_bits_is_builtin_type = tl.io_out_grant_bits_is_builtin_type;
    assign tl.io_in_1_grant_bits_g_type          = tl.io_out_grant_bits_g_type;
    assign tl.io_in_1_grant_bits_data            = tl.io_out_grant_bits_data;

endmodule

// File: tb/tb_uncached_tilelink_client_arbiter.sv
// Bench for the two-client uncached TileLink arbiter: directed scenarios with
// literal expectations, then randomized traffic against a queue-free behavioural model.
module tb_uncached_tilelink_client_arbiter;

    logic clk;
    logic reset;
    logic io_chosen;

    uncached_tilelink_client_arbiter_if tl ();

    uncached_tilelink_client_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .tl        (tl),
        .io_chosen (io_chosen)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // stimulus
    logic        st_reset;
    logic [1:0]  st_valid;
    logic [25:0] st_addr [2];
    logic [1:0]  st_id;
    logic [2:0]  st_beat [2];
    logic [1:0]  st_bi;
    logic [2:0]  st_type [2];
    logic [11:0] st_union [2];
    logic [63:0] st_data [2];
    logic [1:0]  st_gready;
    logic        st_oready;
    logic        st_gvalid;
    logic [2:0]  st_gbeat;
    logic [1:0]  st_gid;
    logic        st_gmid;
    logic        st_gbi;
    logic [3:0]  st_gtype;
    logic [63:0] st_gdata;

    // model: last served client, beats still owed by a PutBlock, and who owes them
    int m_last;
    int m_left;
    int m_bown;

    int n_checks;
    int n_fail;

    logic       obs_chosen, obs_fire, obs_out_valid, obs_ready0, obs_ready1;
    logic [1:0] obs_out_id;
    logic       obs_gv0, obs_gv1, obs_g1_id, obs_gready_out;
    logic [3:0] obs_g1_type;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic apply();
        reset = st_reset;
        tl.io_in_0_acquire_valid                = st_valid[0];
        tl.io_in_0_acquire_bits_addr_block      = st_addr[0];
        tl.io_in_0_acquire_bits_client_xact_id  = st_id[0];
        tl.io_in_0_acquire_bits_addr_beat       = st_beat[0];
        tl.io_in_0_acquire_bits_is_builtin_type = st_bi[0];
        tl.io_in_0_acquire_bits_a_type          = st_type[0];
        tl.io_in_0_acquire_bits_union           = st_union[0];
        tl.io_in_0_acquire_bits_data            = st_data[0];
        tl.io_in_0_grant_ready                  = st_gready[0];
        tl.io_in_1_acquire_valid                = st_valid[1];
        tl.io_in_1_acquire_bits_addr_block      = st_addr[1];
        tl.io_in_1_acquire_bits_client_xact_id  = st_id[1];
        tl.io_in_1_acquire_bits_addr_beat       = st_beat[1];
        tl.io_in_1_acquire_bits_is_builtin_type = st_bi[1];
        tl.io_in_1_acquire_bits_a_type          = st_type[1];
        tl.io_in_1_acquire_bits_union           = st_union[1];
        tl.io_in_1_acquire_bits_data            = st_data[1];
        tl.io_in_1_grant_ready                  = st_gready[1];
        tl.io_out_acquire_ready                 = st_oready;
        tl.io_out_grant_valid                   = st_gvalid;
        tl.io_out_grant_bits_addr_beat          = st_gbeat;
        tl.io_out_grant_bits_client_xact_id     = st_gid;
        tl.io_out_grant_bits_manager_xact_id    = st_gmid;
        tl.io_out_grant_bits_is_builtin_type    = st_gbi;
        tl.io_out_grant_bits_g_type             = st_gtype;
        tl.io_out_grant_bits_data               = st_gdata;
    endtask

    task automatic idle();
        st_valid  = 2'b00;
        st_id     = 2'b00;
        st_bi     = 2'b00;
        st_gready = 2'b00;
        for (int k = 0; k < 2; k++) begin
            st_addr[k]  = 26'h0;
            st_beat[k]  = 3'h0;
            st_type[k]  = 3'h0;
            st_union[k] = 12'h0;
            st_data[k]  = 64'h0;
        end
        st_oready = 1'b1;
        st_gvalid = 1'b0;
        st_gbeat  = 3'h0;
        st_gid    = 2'b00;
        st_gmid   = 1'b0;
        st_gbi    = 1'b0;
        st_gtype  = 4'h0;
        st_gdata  = 64'h0;
    endtask

    // Arbitration rule: scan clients starting just after the last one served.
    function automatic int model_owner();
        int lst;
        lst = st_reset ? 1 : m_last;
        if (!st_reset && m_left > 0) return m_bown;
        for (int k = 1; k <= 2; k++) begin
            if (st_valid[(lst + k) % 2]) return (lst + k) % 2;
        end
        return (lst + 1) % 2;
    endfunction

    task automatic check_model();
        int o;
        o = model_owner();
        chk("chosen", 128'(io_chosen), 128'(o));
        chk("acq_valid", 128'(tl.io_out_acquire_valid), 128'(st_valid[o]));
        chk("acq_bits",
            {17'b0, tl.io_out_acquire_bits_addr_block, tl.io_out_acquire_bits_client_xact_id,
             tl.io_out_acquire_bits_addr_beat, tl.io_out_acquire_bits_is_builtin_type,
             tl.io_out_acquire_bits_a_type, tl.io_out_acquire_bits_union, tl.io_out_acquire_bits_data},
            {17'b0, st_addr[o], 1'(o), st_id[o], st_beat[o], st_bi[o], st_type[o], st_union[o], st_data[o]});
        chk("acq_ready0", 128'(tl.io_in_0_acquire_ready), 128'((o == 0) && st_oready));
        chk("acq_ready1", 128'(tl.io_in_1_acquire_ready), 128'((o == 1) && st_oready));
        chk("gnt_valid0", 128'(tl.io_in_0_grant_valid), 128'(st_gvalid && !st_gid[1]));
        chk("gnt_valid1", 128'(tl.io_in_1_grant_valid), 128'(st_gvalid && st_gid[1]));
        chk("gnt_bits0",
            {54'b0, tl.io_in_0_grant_bits_addr_beat, tl.io_in_0_grant_bits_client_xact_id,
             tl.io_in_0_grant_bits_manager_xact_id, tl.io_in_0_grant_bits_is_builtin_type,
             tl.io_in_0_grant_bits_g_type, tl.io_in_0_grant_bits_data},
            {54'b0, st_gbeat, st_gid[0], st_gmid, st_gbi, st_gtype, st_gdata});
        chk("gnt_bits1",
            {54'b0, tl.io_in_1_grant_bits_addr_beat, tl.io_in_1_grant_bits_client_xact_id,
             tl.io_in_1_grant_bits_manager_xact_id, tl.io_in_1_grant_bits_is_builtin_type,
             tl.io_in_1_grant_bits_g_type, tl.io_in_1_grant_bits_data},
            {54'b0, st_gbeat, st_gid[0], st_gmid, st_gbi, st_gtype, st_gdata});
        chk("gnt_ready", 128'(tl.io_out_grant_ready), 128'(st_gready[st_gid[1]]));

        obs_chosen     = io_chosen;
        obs_out_valid  = tl.io_out_acquire_valid;
        obs_fire       = tl.io_out_acquire_valid & st_oready;
        obs_out_id     = tl.io_out_acquire_bits_client_xact_id;
        obs_ready0     = tl.io_in_0_acquire_ready;
        obs_ready1     = tl.io_in_1_acquire_ready;
        obs_gv0        = tl.io_in_0_grant_valid;
        obs_gv1        = tl.io_in_1_grant_valid;
        obs_g1_id      = tl.io_in_1_grant_bits_client_xact_id;
        obs_g1_type    = tl.io_in_1_grant_bits_g_type;
        obs_gready_out = tl.io_out_grant_ready;
    endtask

    task automatic update_model();
        int o;
        o = model_owner();
        if (st_reset) begin
            m_last = 1;
            m_left = 0;
        end else if (st_valid[o] && st_oready) begin
            m_last = o;
            if (m_left > 0) begin
                m_left--;
            end else if (st_bi[o] && st_type[o] == 3'h3) begin
                m_bown = o;
                m_left = 7;
            end
        end
    endtask

    task automatic step();
        apply();
        @(negedge clk);
        check_model();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        idle();
        st_reset = 1'b1;
        repeat (n) step();
        st_reset = 1'b0;
    endtask

    task automatic randomize_stim();
        st_reset = ($urandom_range(0, 49) == 0);
        for (int k = 0; k < 2; k++) begin
            st_valid[k] = !st_reset && ($urandom_range(0, 3) != 0);
            st_addr[k]  = 26'($urandom);
            st_id[k]    = 1'($urandom);
            st_beat[k]  = 3'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                st_bi[k]   = 1'b1;
                st_type[k] = 3'h3;
            end else begin
                st_bi[k]   = 1'($urandom);
                st_type[k] = 3'($urandom);
            end
            st_union[k]  = 12'($urandom);
            st_data[k]   = {$urandom, $urandom};
            st_gready[k] = 1'($urandom);
        end
        st_oready = ($urandom_range(0, 3) != 0);
        st_gvalid = 1'($urandom);
        st_gbeat  = 3'($urandom);
        st_gid    = 2'($urandom);
        st_gmid   = 1'($urandom);
        st_gbi    = 1'($urandom);
        st_gtype  = 4'($urandom);
        st_gdata  = {$urandom, $urandom};
    endtask

    initial begin
        int exp_own [4];
        int exp_id [4];
        int n1;
        int nf;
        int wrong;

        n_checks = 0;
        n_fail   = 0;
        m_last   = 1;
        m_left   = 0;
        m_bown   = 0;
        idle();
        st_reset = 1'b1;
        apply();
        @(posedge clk);
        #1;

        // reset held, nobody valid
        step();
        chk("rst_chosen", 128'(obs_chosen), 128'(0));
        chk("rst_ready1", 128'(obs_ready1), 128'(0));

        // first Get from client 0 after reset
        do_reset(2);
        st_valid[0] = 1'b1;
        st_id[0]    = 1'b1;
        st_type[0]  = 3'h0;
        step();
        chk("get_valid", 128'(obs_out_valid), 128'(1));
        chk("get_id", 128'(obs_out_id), 128'(2'b01));
        chk("get_chosen", 128'(obs_chosen), 128'(0));
        chk("get_ready0", 128'(obs_ready0), 128'(1));
        chk("get_ready1", 128'(obs_ready1), 128'(0));

        // continuous contention alternates strictly
        do_reset(2);
        exp_own = '{0, 1, 0, 1};
        exp_id  = '{0, 3, 0, 3};
        st_valid = 2'b11;
        st_id    = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("alt_owner", 128'(obs_chosen), 128'(exp_own[i]));
            chk("alt_id", 128'(obs_out_id), 128'(exp_id[i]));
        end

        // client 1 PutBlock holds the port for 8 beats against a waiting client 0
        do_reset(2);
        st_valid[0] = 1'b1;
        step();
        st_valid[1] = 1'b1;
        st_bi[1]    = 1'b1;
        st_type[1]  = 3'h3;
        n1 = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (obs_fire && obs_chosen) n1++;
        end
        step();
        chk("pb_c1_fires", 128'(n1), 128'(8));
        chk("pb_c0_after", 128'(obs_chosen), 128'(0));
        chk("pb_c0_fire", 128'(obs_fire), 128'(1));

        // PutBlock with ready toggling: exactly 8 fires then release
        do_reset(2);
        st_valid   = 2'b11;
        st_bi[0]   = 1'b1;
        st_type[0] = 3'h3;
        nf = 0;
        wrong = 0;
        for (int i = 0; i < 16; i++) begin
            st_oready = (i % 2 == 0);
            step();
            if (obs_fire) begin
                if (obs_chosen == 1'b0) nf++;
                else wrong++;
            end
        end
        chk("tog_fires", 128'(nf), 128'(8));
        chk("tog_wrong", 128'(wrong), 128'(0));
        st_oready = 1'b1;
        step();
        chk("tog_release", 128'(obs_chosen), 128'(1));

        // grant steered to client 1
        idle();
        st_gvalid = 1'b1;
        st_gid    = 2'b10;
        st_gtype  = 4'h5;
        st_gready = 2'b10;
        step();
        chk("gnt_v1", 128'(obs_gv1), 128'(1));
        chk("gnt_v0", 128'(obs_gv0), 128'(0));
        chk("gnt_id1", 128'(obs_g1_id), 128'(0));
        chk("gnt_type1", 128'(obs_g1_type), 128'(4'h5));
        chk("gnt_rdy_hi", 128'(obs_gready_out), 128'(1));
        st_gready = 2'b01;
        step();
        chk("gnt_rdy_lo", 128'(obs_gready_out), 128'(0));

        // reset after beat 3 of a client-0 PutBlock abandons the lock
        do_reset(2);
        st_valid[0] = 1'b1;
        st_bi[0]    = 1'b1;
        st_type[0]  = 3'h3;
        repeat (3) step();
        do_reset(1);
        st_valid[1] = 1'b1;
        step();
        chk("rstmid_chosen", 128'(obs_chosen), 128'(1));
        chk("rstmid_fire", 128'(obs_fire), 128'(1));

        do_reset(2);
        repeat (3000) begin
            randomize_stim();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
